// File: rtl/crossbar_rr_if.sv
// Request/ack/response bundle between the masters, the crossbar and the slaves.
// The crossbar sits on the xbar modport; bus agents use master/slave.
interface crossbar_rr_if #(
  parameter int MASTERS = 4,
  parameter int SLAVES  = 4,
  parameter int AW      = 32,
  parameter int DW      = 32
);
  localparam int SW = $clog2(SLAVES);

  logic [MASTERS-1:0]                m_req;
  logic [MASTERS-1:0]                m_cmd;
  logic [MASTERS-1:0][AW-1:0]        m_addr;
  logic [MASTERS-1:0][DW-1:0]        m_wdata;
  logic [MASTERS-1:0]                m_ack;
  logic [MASTERS-1:0]                m_resp;
  logic [MASTERS-1:0][DW-1:0]        m_rdata;
  logic [MASTERS-1:0]                m_err;

  logic [SLAVES-1:0]                 s_req;
  logic [SLAVES-1:0]                 s_cmd;
  logic [SLAVES-1:0][AW-SW-1:0]      s_addr;
  logic [SLAVES-1:0][DW-1:0]         s_wdata;
  logic [SLAVES-1:0]                 s_ack;
  logic [SLAVES-1:0]                 s_resp;
  logic [SLAVES-1:0][DW-1:0]         s_rdata;

  modport xbar (
    input  m_req, m_cmd, m_addr, m_wdata, s_ack, s_resp, s_rdata,
    output m_ack, m_resp, m_rdata, m_err, s_req, s_cmd, s_addr, s_wdata
  );

  modport master (
    output m_req, m_cmd, m_addr, m_wdata,
    input  m_ack, m_resp, m_rdata, m_err
  );

  modport slave (
    input  s_req, s_cmd, s_addr, s_wdata,
    output s_ack, s_resp, s_rdata
  );
endinterface

// File: rtl/crossbar_rr.sv
// MASTERS x SLAVES request/ack/response crossbar: each slave port has its own
// round-robin arbiter and FSM; unmapped slave selects get a decode-error reply.
module crossbar_rr #(
  parameter int MASTERS = 4,
  parameter int SLAVES  = 4,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic            clk,
  input  logic            rst,
  crossbar_rr_if.xbar     io_bus
);
  localparam int SW  = $clog2(SLAVES);
  localparam int MW  = $clog2(MASTERS);
  localparam int SAW = AW - SW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_ACK,
    S_WAIT_RESP
  } state_t;

  state_t                       r_state     [SLAVES];
  state_t                       w_stateNext [SLAVES];
  logic [MW-1:0]                r_rrPtr     [SLAVES];
  logic [MW-1:0]                r_owner     [SLAVES];
  logic [MW-1:0]                w_grantIdx  [SLAVES];
  logic [SLAVES-1:0]            w_grantValid;
  logic [SLAVES-1:0]            w_ackEv;
  logic [SLAVES-1:0]            w_respEv;

  logic [SLAVES-1:0]            r_sReq;
  logic [SLAVES-1:0]            r_sCmd;
  logic [SLAVES-1:0][SAW-1:0]   r_sAddr;
  logic [SLAVES-1:0][DW-1:0]    r_sWdata;

  logic [MASTERS-1:0]           r_mAck;
  logic [MASTERS-1:0]           r_mResp;
  logic [MASTERS-1:0]           r_mErr;
  logic [MASTERS-1:0][DW-1:0]   r_mRdata;
  logic [MASTERS-1:0]           r_busy;

  logic [MASTERS-1:0]           w_mAckNext;
  logic [MASTERS-1:0]           w_mRespNext;
  logic [MASTERS-1:0]           w_mErrNext;
  logic [MASTERS-1:0][DW-1:0]   w_mRdataNext;
  logic [MASTERS-1:0]           w_busyNext;

  logic [SW-1:0]                w_sel [MASTERS];
  logic [MASTERS-1:0]           w_decErr;
  logic [SLAVES-1:0][MASTERS-1:0] w_elig;

  always_comb begin
    for (int m = 0; m < MASTERS; m++) begin
      w_sel[m] = io_bus.m_addr[m][AW-1 -: SW];
    end
  end

  // Selects past the last slave only exist when SLAVES is not a power of two.
  generate
    if (SLAVES < (1 << SW)) begin : g_decErr
      always_comb begin
        for (int m = 0; m < MASTERS; m++) begin
          w_decErr[m] = io_bus.m_req[m] & ~r_busy[m] & (w_sel[m] >= SW'(SLAVES));
        end
      end
    end else begin : g_noDecErr
      assign w_decErr = '0;
    end
  endgenerate

  always_comb begin
    for (int s = 0; s < SLAVES; s++) begin
      for (int m = 0; m < MASTERS; m++) begin
        w_elig[s][m] = io_bus.m_req[m] & ~r_busy[m] & (w_sel[m] == SW'(s));
      end
    end
  end

  always_comb begin
    for (int s = 0; s < SLAVES; s++) begin
      logic          found;
      int            idx;
      logic [MW-1:0] cand;
      w_stateNext[s]  = r_state[s];
      w_grantValid[s] = 1'b0;
      w_grantIdx[s]   = '0;
      w_ackEv[s]      = 1'b0;
      w_respEv[s]     = 1'b0;
      found           = 1'b0;
      idx             = 0;
      cand            = '0;
      case (r_state[s])
        S_IDLE: begin
          // Scan from the round-robin pointer, wrapping past the last master.
          for (int k = 0; k < MASTERS; k++) begin
            idx = int'(r_rrPtr[s]) + k;
            if (idx >= MASTERS) idx = idx - MASTERS;
            cand = MW'(idx);
            if (!found && w_elig[s][cand]) begin
              found         = 1'b1;
              w_grantIdx[s] = cand;
            end
          end
          if (found) begin
            w_grantValid[s] = 1'b1;
            w_stateNext[s]  = S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          if (io_bus.s_ack[s]) begin
            w_ackEv[s] = 1'b1;
            if (io_bus.s_resp[s]) begin
              w_respEv[s]    = 1'b1;
              w_stateNext[s] = S_IDLE;
            end else begin
              w_stateNext[s] = S_WAIT_RESP;
            end
          end
        end
        S_WAIT_RESP: begin
          if (io_bus.s_resp[s]) begin
            w_respEv[s]    = 1'b1;
            w_stateNext[s] = S_IDLE;
          end
        end
        default: w_stateNext[s] = S_IDLE;
      endcase
    end
  end

  // At most one slave can own a given master, so owner writes never collide.
  always_comb begin
    w_mAckNext   = w_decErr;
    w_mRespNext  = w_decErr;
    w_mErrNext   = w_decErr;
    w_busyNext   = r_busy;
    w_mRdataNext = r_mRdata;
    for (int m = 0; m < MASTERS; m++) begin
      if (w_decErr[m]) w_mRdataNext[m] = '0;
    end
    for (int s = 0; s < SLAVES; s++) begin
      if (w_ackEv[s]) w_mAckNext[r_owner[s]] = 1'b1;
      if (w_respEv[s]) begin
        w_mRespNext[r_owner[s]]  = 1'b1;
        w_busyNext[r_owner[s]]   = 1'b0;
        w_mRdataNext[r_owner[s]] = r_sCmd[s] ? '0 : io_bus.s_rdata[s];
      end
      if (w_grantValid[s]) w_busyNext[w_grantIdx[s]] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SLAVES; s++) begin
        r_state[s] <= S_IDLE;
        r_rrPtr[s] <= '0;
        r_owner[s] <= '0;
      end
      r_sReq   <= '0;
      r_sCmd   <= '0;
      r_sAddr  <= '0;
      r_sWdata <= '0;
    end else begin
      for (int s = 0; s < SLAVES; s++) begin
        r_state[s] <= w_stateNext[s];
        if (w_grantValid[s]) begin
          r_owner[s]  <= w_grantIdx[s];
          r_rrPtr[s]  <= (w_grantIdx[s] == MW'(MASTERS - 1)) ? '0 : w_grantIdx[s] + 1'b1;
          r_sReq[s]   <= 1'b1;
          r_sCmd[s]   <= io_bus.m_cmd[w_grantIdx[s]];
          r_sAddr[s]  <= io_bus.m_addr[w_grantIdx[s]][SAW-1:0];
          r_sWdata[s] <= io_bus.m_cmd[w_grantIdx[s]] ? io_bus.m_wdata[w_grantIdx[s]] : '0;
        end else if (w_ackEv[s]) begin
          r_sReq[s] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mAck   <= '0;
      r_mResp  <= '0;
      r_mErr   <= '0;
      r_mRdata <= '0;
      r_busy   <= '0;
    end else begin
      r_mAck   <= w_mAckNext;
      r_mResp  <= w_mRespNext;
      r_mErr   <= w_mErrNext;
      r_mRdata <= w_mRdataNext;
      r_busy   <= w_busyNext;
    end
  end

  assign io_bus.m_ack   = r_mAck;
  assign io_bus.m_resp  = r_mResp;
  assign io_bus.m_err   = r_mErr;
  assign io_bus.m_rdata = r_mRdata;
  assign io_bus.s_req   = r_sReq;
  assign io_bus.s_cmd   = r_sCmd;
  assign io_bus.s_addr  = r_sAddr;
  assign io_bus.s_wdata = r_sWdata;
endmodule
